// File: rtl/bmp_stream_sequencer.sv
// BMP frame sequencer: validates the header on the fly, loads bytes into the pixel buffer,
// then streams 24-bit pixels out. Define SEQ_HDR_CHECK_EN to enable header checking.
module bmp_stream_sequencer #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned OFFSET = 54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        pp_ena,
  output logic [7:0]  pp_wdata,
  input  logic        pp_ok,
  input  logic [7:0]  pp_rdata,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [23:0] px_data,
  output logic        px_eol,
  output logic        px_eof,
  output logic        hdr_err,
  output logic        rx_ovr,
  output logic        frame_done,
  output logic [2:0]  state
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned TOTAL = OFFSET + 3 * NPIX;
  localparam int unsigned BCW   = $clog2(TOTAL + 1);
  localparam int unsigned PXW   = $clog2(NPIX + 1);
  localparam int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHeader = 3'd1,
    StBody   = 3'd2,
    StWaitOk = 3'd3,
    StStream = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } state_e;

  state_e r_state, w_state_d;

  logic [BCW-1:0] r_bc;
  logic           r_ld_ena;
  logic [7:0]     r_wdata;
  logic           r_hdr_err, r_rx_ovr, r_frame_done;
  logic [1:0]     r_fph;
  logic           r_rd_vld;
  logic [1:0]     r_rd_idx;
  logic [7:0]     r_b0, r_b1;
  logic [PXW-1:0] r_fcnt, r_lcnt;
  logic [CW-1:0]  r_col;
  logic           r_px_valid, r_px_eol, r_px_eof;
  logic [23:0]    r_px_data;
  logic           r_pend, r_pend_eol, r_pend_eof;
  logic [23:0]    r_pend_data;

  logic           w_load, w_hdr_bad, w_fwd, w_accept, w_start, w_fetch, w_land;
  logic           w_land_eol, w_land_eof;
  logic [23:0]    w_land_data;
  logic [BCW-1:0] w_bc_inc;

  assign w_load   = rx_valid && (r_state == StIdle || r_state == StHeader || r_state == StBody);
  assign w_fwd    = w_load && !w_hdr_bad;
  assign w_bc_inc = r_bc + BCW'(1);

`ifdef SEQ_HDR_CHECK_EN
  logic [31:0] w_idx, w_fld;
  logic [1:0]  w_base, w_rel;
  logic        w_chk;
  logic [7:0]  w_exp;

  // Each checked field is little-endian; w_rel selects the byte within it.
  always_comb begin
    w_idx  = 32'(r_bc);
    w_chk  = 1'b1;
    w_fld  = '0;
    w_base = 2'd0;
    if (w_idx <= 32'd1) begin
      w_fld = 32'h0000_4D42;
    end else if (w_idx >= 32'd10 && w_idx <= 32'd13) begin
      w_fld  = 32'(OFFSET);
      w_base = 2'd2;
    end else if (w_idx >= 32'd18 && w_idx <= 32'd21) begin
      w_fld  = 32'(WIDTH);
      w_base = 2'd2;
    end else if (w_idx >= 32'd22 && w_idx <= 32'd25) begin
      w_fld  = 32'(HEIGHT);
      w_base = 2'd2;
    end else if (w_idx == 32'd28 || w_idx == 32'd29) begin
      w_fld = 32'd24;
    end else begin
      w_chk = 1'b0;
    end
    w_rel     = w_idx[1:0] - w_base;
    w_exp     = 8'(w_fld >> {w_rel, 3'b000});
    w_hdr_bad = w_chk && (rx_data != w_exp);
  end
`else
  assign w_hdr_bad = 1'b0;
`endif

  // Next fetch may overlap the landing of the previous pixel; r_pend absorbs a stalled landing.
  assign w_accept = r_px_valid && px_ready;
  assign w_start  = (r_state == StStream) && (r_fph == 2'd0) && !r_pend &&
                    (!r_px_valid || w_accept) && (r_fcnt < PXW'(NPIX));
  assign w_fetch  = w_start || ((r_state == StStream) && (r_fph != 2'd0));
  assign w_land   = r_rd_vld && (r_rd_idx == 2'd2);
  assign w_land_data = {r_b0, r_b1, pp_rdata};
  assign w_land_eol  = (r_col == CW'(WIDTH - 1));
  assign w_land_eof  = (r_lcnt == PXW'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StHeader, StBody: begin
        if (w_load) begin
          if (w_hdr_bad)                     w_state_d = StError;
          else if (w_bc_inc == BCW'(TOTAL))  w_state_d = StWaitOk;
          else if (w_bc_inc >= BCW'(OFFSET)) w_state_d = StBody;
          else                               w_state_d = StHeader;
        end
      end
      StWaitOk: if (pp_ok) w_state_d = StStream;
      StStream: if (w_accept && r_px_eof) w_state_d = StDone;
      default:  w_state_d = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bc         <= '0;
      r_ld_ena     <= 1'b0;
      r_wdata      <= '0;
      r_hdr_err    <= 1'b0;
      r_rx_ovr     <= 1'b0;
      r_frame_done <= 1'b0;
      r_fph        <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_idx     <= '0;
      r_b0         <= '0;
      r_b1         <= '0;
      r_fcnt       <= '0;
      r_lcnt       <= '0;
      r_col        <= '0;
      r_px_valid   <= 1'b0;
      r_px_data    <= '0;
      r_px_eol     <= 1'b0;
      r_px_eof     <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_data  <= '0;
      r_pend_eol   <= 1'b0;
      r_pend_eof   <= 1'b0;
    end else begin
      r_ld_ena <= w_fwd;
      if (w_fwd) begin
        r_wdata <= rx_data;
        r_bc    <= w_bc_inc;
      end
      if (w_load && w_hdr_bad) r_hdr_err <= 1'b1;
      if (rx_valid && (r_state == StWaitOk || r_state == StStream || r_state == StDone)) begin
        r_rx_ovr <= 1'b1;
      end
      if (r_state == StStream && w_accept && r_px_eof) r_frame_done <= 1'b1;

      if (w_fetch) r_fph <= (r_fph == 2'd2) ? 2'd0 : r_fph + 2'd1;
      if (w_start) r_fcnt <= r_fcnt + PXW'(1);
      r_rd_vld <= w_fetch;
      r_rd_idx <= r_fph;
      if (r_rd_vld && r_rd_idx == 2'd0) r_b0 <= pp_rdata;
      if (r_rd_vld && r_rd_idx == 2'd1) r_b1 <= pp_rdata;

      if (w_land) begin
        r_lcnt <= r_lcnt + PXW'(1);
        r_col  <= w_land_eol ? '0 : r_col + CW'(1);
      end

      if (w_land && (!r_px_valid || w_accept)) begin
        r_px_valid <= 1'b1;
        r_px_data  <= w_land_data;
        r_px_eol   <= w_land_eol;
        r_px_eof   <= w_land_eof;
      end else if (w_land) begin
        r_pend      <= 1'b1;
        r_pend_data <= w_land_data;
        r_pend_eol  <= w_land_eol;
        r_pend_eof  <= w_land_eof;
      end else if (w_accept) begin
        if (r_pend) begin
          r_px_data <= r_pend_data;
          r_px_eol  <= r_pend_eol;
          r_px_eof  <= r_pend_eof;
          r_pend    <= 1'b0;
        end else begin
          r_px_valid <= 1'b0;
        end
      end
    end
  end

  assign pp_ena     = r_ld_ena | w_fetch;
  assign pp_wdata   = r_wdata;
  assign px_valid   = r_px_valid;
  assign px_data    = r_px_data;
  assign px_eol     = r_px_eol;
  assign px_eof     = r_px_eof;
  assign hdr_err    = r_hdr_err;
  assign rx_ovr     = r_rx_ovr;
  assign frame_done = r_frame_done;
  assign state      = r_state;

endmodule

// File: tb/tb_bmp_stream_sequencer.sv
// Scoreboard bench for bmp_stream_sequencer on a small 4x3 image with a pixel-buffer model.
module tb_bmp_stream_sequencer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int OFF   = 54;
  localparam int NPIX  = W * H;
  localparam int TOTAL = OFF + 3 * NPIX;
`ifdef SEQ_HDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst, rx_valid, pp_ena, pp_ok, px_valid, px_ready;
  logic        px_eol, px_eof, hdr_err, rx_ovr, frame_done;
  logic [7:0]  rx_data, pp_wdata, pp_rdata;
  logic [23:0] px_data;
  logic [2:0]  state;

  bmp_stream_sequencer #(.WIDTH(W), .HEIGHT(H), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .pp_ena(pp_ena),
    .pp_wdata(pp_wdata), .pp_ok(pp_ok), .pp_rdata(pp_rdata), .px_valid(px_valid),
    .px_ready(px_ready), .px_data(px_data), .px_eol(px_eol), .px_eof(px_eof),
    .hdr_err(hdr_err), .rx_ovr(rx_ovr), .frame_done(frame_done), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel buffer: stores every written byte, returns pixel bytes (after the header) on reads.
  logic [7:0] mem [TOTAL];
  int wptr, rptr, ena_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      wptr <= 0; rptr <= 0; ena_cnt <= 0; pp_ok <= 1'b0; pp_rdata <= 8'h00;
    end else if (pp_ena) begin
      ena_cnt <= ena_cnt + 1;
      if (!pp_ok) begin
        mem[wptr] <= pp_wdata;
        wptr <= wptr + 1;
        if (wptr == TOTAL - 1) pp_ok <= 1'b1;
      end else begin
        pp_rdata <= (OFF + rptr < TOTAL) ? mem[OFF + rptr] : 8'hEE;
        rptr <= rptr + 1;
      end
    end
  end

  int n_cmp, n_fail, cyc, acc_cnt, eol_cnt, eof_cnt, first_t, last_t;
  logic [7:0]  wr_q [$];
  logic [25:0] px_q [$];
  logic [7:0]  hdr [OFF];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({pp_ena, pp_wdata, px_valid, px_data, px_eol, px_eof,
                hdr_err, rx_ovr, frame_done, state});
  endfunction

  function automatic logic [7:0] fbyte(input int seed, input int i);
    return (i < OFF) ? hdr[i] : 8'(seed * 53 + i * 7 + (i >> 2) * 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic        held_v;
    logic [25:0] held;
    logic [25:0] e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        held_v = 1'b0;
      end else begin
        if (pp_ena && !pp_ok) begin
          chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
          if (wr_q.size() != 0) chk("wr_data", 64'(pp_wdata), 64'(wr_q.pop_front()));
        end
        if (held_v) chk("px_hold", 64'({px_valid, px_data, px_eol, px_eof}), 64'({1'b1, held}));
        if (px_valid && px_ready) begin
          chk("px_expected", 64'(px_q.size() != 0), 64'd1);
          if (px_q.size() != 0) begin
            e = px_q.pop_front();
            chk("px_pixel", 64'({px_data, px_eol, px_eof}), 64'(e));
          end
          acc_cnt++;
          if (px_eol) eol_cnt++;
          if (px_eof) eof_cnt++;
          if (first_t < 0) first_t = cyc;
          last_t = cyc;
        end
        held_v = px_valid && !px_ready;
        held   = {px_data, px_eol, px_eof};
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    tick();
    chk("rst_outputs", outs(), 64'd0);
    tick();
    wr_q.delete();
    px_q.delete();
    acc_cnt = 0; eol_cnt = 0; eof_cnt = 0; first_t = -1; last_t = -1;
    rst = 1'b1;
  endtask

  task automatic send_frame(input int seed, input int nbytes);
    if (nbytes == TOTAL) begin
      for (int p = 0; p < NPIX; p++) begin
        px_q.push_back({fbyte(seed, OFF + 3 * p), fbyte(seed, OFF + 3 * p + 1),
                        fbyte(seed, OFF + 3 * p + 2), (p % W) == W - 1, p == NPIX - 1});
      end
    end
    for (int i = 0; i < nbytes; i++) begin
      rx_valid = 1'b1;
      rx_data  = fbyte(seed, i);
      wr_q.push_back(rx_data);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !frame_done; i++) tick();
    chk("frame_done", 64'(frame_done), 64'd1);
    chk("state_done", 64'(state), 64'd5);
    chk("px_count", 64'(acc_cnt), 64'(NPIX));
    chk("eol_count", 64'(eol_cnt), 64'(H));
    chk("eof_count", 64'(eof_cnt), 64'd1);
    chk("px_q_empty", 64'(px_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; px_ready = 1'b0;
    n_cmp = 0; n_fail = 0; cyc = 0;
    acc_cnt = 0; eol_cnt = 0; eof_cnt = 0; first_t = -1; last_t = -1;
    for (int i = 0; i < OFF; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h42; hdr[1] = 8'h4D; hdr[2] = 8'(TOTAL); hdr[10] = 8'(OFF); hdr[14] = 8'd40;
    hdr[18] = 8'(W); hdr[22] = 8'(H); hdr[26] = 8'd1; hdr[28] = 8'd24;
    fork
      monitor();
    join_none

    // Full frame, consumer always ready.
    do_reset();
    px_ready = 1'b1;
    send_frame(1, TOTAL);
    wait_done(500);
    chk("throughput", 64'(last_t - first_t), 64'(3 * (NPIX - 1)));
    chk("hdr_err_clean", 64'(hdr_err), 64'd0);
    chk("rx_ovr_clean", 64'(rx_ovr), 64'd0);
    repeat (5) tick();
    chk("strobes_total", 64'(ena_cnt), 64'(TOTAL + 3 * NPIX));

    // Magic byte1 = 0x4E.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 1) ? 8'h4E : hdr[i];
      if (!CHK || i == 0) wr_q.push_back(rx_data);
      tick();
      if (i == 1) begin
        chk("magic_hdr_err", 64'(hdr_err), 64'(CHK));
        chk("magic_state", 64'(state), CHK ? 64'd6 : 64'd1);
      end
    end
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("magic_strobes", 64'(ena_cnt), CHK ? 64'd1 : 64'd10);
    chk("magic_wr_q", 64'(wr_q.size()), 64'd0);

    // Width field mismatch at byte 18.
    do_reset();
    for (int i = 0; i <= 18; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 18) ? 8'(W + 1) : hdr[i];
      if (!CHK || i < 18) wr_q.push_back(rx_data);
      tick();
      if (i == 18) begin
        chk("width_hdr_err", 64'(hdr_err), 64'(CHK));
        chk("width_state", 64'(state), CHK ? 64'd6 : 64'd1);
      end
    end
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("width_strobes", 64'(ena_cnt), CHK ? 64'd18 : 64'd19);

    // Consumer stalls every 4 cycles, plus a stray byte during STREAM.
    do_reset();
    send_frame(2, TOTAL);
    for (int i = 0; i < 200 && state != 3'd4; i++) tick();
    chk("reach_stream", 64'(state), 64'd4);
    for (int c = 0; c < 600 && !frame_done; c++) begin
      px_ready = ((c / 4) % 2) == 0;
      rx_valid = (c == 10);
      rx_data  = 8'hAA;
      tick();
    end
    rx_valid = 1'b0;
    px_ready = 1'b1;
    wait_done(10);
    chk("rx_ovr_set", 64'(rx_ovr), 64'd1);
    chk("stall_strobes", 64'(ena_cnt), 64'(TOTAL + 3 * NPIX));

    // Reset mid-body, then a fresh frame.
    do_reset();
    send_frame(3, 70);
    repeat (2) tick();
    chk("midbody_state", 64'(state), 64'd2);
    do_reset();
    send_frame(4, TOTAL);
    wait_done(500);
    chk("fresh_strobes", 64'(ena_cnt), 64'(TOTAL + 3 * NPIX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bmp_stream_sequencer.md
# bmp_stream_sequencer

Sequences the BMP frame-buffer path: accepts the raw byte stream from the UART receiver, validates the 54-byte BMP header on the fly, and forwards every byte to the pixel buffer as write strobes. After the buffer reports load complete, it issues read strobes to the buffer. It packs the returned bytes into 24-bit pixels and presents them to the display side over a valid/ready handshake, with line and frame markers.

## Interface
- WIDTH, 320, image width in pixels
- HEIGHT, 256, image height in pixels
- OFFSET, 54, header length in bytes (BMP pixel-data offset)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- rx_valid  in  1  one-cycle strobe, new byte on rx_data
- rx_data  in  8  received byte
- pp_ena  out  1  strobe to pixel buffer (write during load, read during stream)
- pp_wdata  out  8  byte to pixel buffer
- pp_ok  in  1  pixel buffer load-complete flag
- pp_rdata  in  8  byte returned by pixel buffer, registered one clock after pp_ena
- px_valid  out  1  pixel available
- px_ready  in  1  consumer accepts pixel
- px_data  out  24  {b0,b1,b2}, bytes in buffer return order
- px_eol  out  1  px_data is the last pixel of a line
- px_eof  out  1  px_data is the last pixel of the frame
- hdr_err  out  1  sticky header mismatch
- rx_ovr  out  1  sticky: byte arrived outside load phase
- frame_done  out  1  sticky: all WIDTH*HEIGHT pixels consumed
- state  out  3  IDLE=0, HEADER=1, BODY=2, WAIT_OK=3, STREAM=4, DONE=5, ERROR=6

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0. Shares rst with the pixel buffer. A reset at any point restarts both blocks from an empty frame.
- Byte counter bc has width $clog2(OFFSET+3*WIDTH*HEIGHT+1).
- IDLE: the first rx_valid moves to HEADER. The byte is forwarded and counts as byte 0.
- HEADER/BODY: each rx_valid produces pp_ena=1 and pp_wdata=rx_data on the next cycle, and bc is incremented.
- Header checks (little-endian), applied as each byte arrives:
  - byte0=0x42, byte1=0x4D;
  - bytes 10–13 = OFFSET;
  - bytes 18–21 = WIDTH;
  - bytes 22–25 = HEIGHT;
  - bytes 28–29 = 24.
- Any header mismatch:
  - the offending byte is not forwarded;
  - hdr_err=1;
  - go to ERROR.
- The HEADER→BODY transition happens when bc reaches OFFSET.
- BODY→WAIT_OK happens when bc reaches OFFSET+3*WIDTH*HEIGHT, with the last byte forwarded.
- WAIT_OK: no strobes. Go to STREAM in the cycle after pp_ok is sampled high.
- STREAM: a pixel fetch is three consecutive pp_ena pulses. A fetch starts only when the output register is empty, or is being consumed that cycle (px_valid&&px_ready).
- Pixel and line counters:
  - px_eol is set when the column counter equals WIDTH-1;
  - px_eof is set on pixel WIDTH*HEIGHT-1.
- The pixel counter stops at WIDTH*HEIGHT: no further fetches are issued.
- When the eof pixel is consumed, go to DONE and set frame_done=1.
- DONE and ERROR are terminal until reset. No strobes are issued in either state.
- rx_valid in WAIT_OK, STREAM or DONE:
  - the byte is ignored;
  - rx_ovr=1.
- rx_valid in ERROR is ignored silently.

## Timing
- Load latency: rx_valid in cycle k gives pp_ena in cycle k+1. Back-to-back rx_valid is supported at one byte per cycle.
- Fetch: pp_ena in cycles k, k+1, k+2. pp_rdata is sampled at the edges ending k+1, k+2 and k+3.
- px_valid, px_data, px_eol and px_eof are updated in cycle k+3.
- Throughput: one pixel per 3 cycles when px_ready is held high.
- Handshake rules:
  - px_data, px_eol and px_eof are stable while px_valid=1 and px_ready=0;
  - px_valid drops in the cycle after acceptance unless a new pixel completes in that same cycle.
- Simultaneous accept and completion: the new pixel replaces the old one, and px_valid stays 1.
- frame_done rises in the cycle after the eof pixel is accepted.

## Configuration
- SEQ_HDR_CHECK_EN defined: header checks as above; hdr_err and ERROR are reachable.
- Not defined:
  - header bytes are forwarded unchecked;
  - hdr_err is tied 0;
  - ERROR is unreachable.
- Not defined, counting: byte counting, BODY→WAIT_OK and STREAM behave identically.

## Test plan
- Valid header followed by 245760 bytes, then pp_ok=1, px_ready=1:
  - exactly 245814 load strobes;
  - 81920 pixels;
  - px_eol every 320th pixel;
  - px_eof on the last pixel;
  - frame_done=1;
  - state 5.
- Header byte1=0x4E:
  - hdr_err=1 and state 6 one cycle later;
  - exactly 1 pp_ena total;
  - no further strobes.
- Width field 0x0000_0140 replaced by 0x0000_0100 → hdr_err=1 after byte 18.
- Stream with px_ready toggled every 4 cycles:
  - px_data held stable while stalled;
  - no pixel lost or duplicated;
  - pixel count 81920.
- rx_valid pulse in STREAM → rx_ovr=1 and no pp_ena in that cycle.
- rst low mid-BODY (bc=1000) → all outputs 0 and state 0; a fresh valid frame then completes normally.
